// File: rtl/clk_division_pkg.sv
// division_pkg: shared constants and helpers for the clock divider.
//   DEFAULT_DIV_RATIO : default input cycles per output period
//   SYS_CLK_HZ        : nominal system clock rate
//   cnt_width()       : phase counter width for a given ratio
package division_pkg;

  localparam int DEFAULT_DIV_RATIO = 1000;
  localparam int SYS_CLK_HZ        = 1000;

  // $clog2 of 1 is 0, so the width is clamped to at least one bit.
  function automatic int cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/clk_division_if.sv
// clk_division_if: enable / divided-clock bundle for clk_division.
//   en      : count enable (master -> divider)
//   clk_out : divided clock (divider -> master)
//   tick    : one-cycle strobe on each clk_out rise, present only when
//             DIVISION_TICK_EN is defined
interface clk_division_if;
  logic en;
  logic clk_out;
`ifdef DIVISION_TICK_EN
  logic tick;

  modport master (output en, input clk_out, input tick);
  modport slave  (input en, output clk_out, output tick);
`else
  modport master (output en, input clk_out);
  modport slave  (input en, output clk_out);
`endif
endinterface

// File: rtl/clk_division.sv
// clk_division: integer clock divider with a registered, glitch-free
// divided clock and an optional rising-edge tick strobe.
//   DIV_RATIO : input cycles per output period (>= 2)
//   CNT_W     : phase counter width (derived)
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   div_if    : slave side of clk_division_if (en in; clk_out, tick out)
// Optional feature macro: DIVISION_TICK_EN (adds the tick register/port).
// Odd ratios keep the output low one cycle longer than high.
module clk_division
  import division_pkg::*;
#(
  parameter  int DIV_RATIO = DEFAULT_DIV_RATIO,
  localparam int CNT_W     = cnt_width(DIV_RATIO)
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_division_if.slave div_if
);

  if (DIV_RATIO < 2) begin : g_ratio_chk
    $error("clk_division: DIV_RATIO must be >= 2");
  end

  localparam int             HI_START = DIV_RATIO - DIV_RATIO / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(HI_START);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q;

  // Wrap on DIV_RATIO-1 so unused codes of non-power-of-2 ratios are never hit.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output decodes the next phase so clk_out is a plain register
  // aligned with the counter, with no combinational path from en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else if (div_if.en) begin
      cnt_q     <= cnt_d;
      clk_out_q <= (cnt_d >= CNT_HI);
    end
  end

  assign div_if.clk_out = clk_out_q;

`ifdef DIVISION_TICK_EN
  logic tick_q;

  // Strobe on entry to the high phase; forced low while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= div_if.en && (cnt_d == CNT_HI);
  end

  assign div_if.tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_division.sv
// tb_clk_division: scoreboard bench for clk_division at ratios 1000, 5, 2, 10.
// Stimulus pushes hand-computed edge events (kind, cycle); a monitor pops and
// compares whenever a DUT output changes or tick is seen high.
module tb_clk_division;

  localparam int K_FALL = 0;
  localparam int K_RISE = 1;
  localparam int K_TICK = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_a, rst_b, rst_c, rst_d;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ev_t  exp_q [4][$];
  logic [3:0] co_s, tk_s;
  logic [3:0] prev_co = 4'b0;

  clk_division_if if_a ();
  clk_division_if if_b ();
  clk_division_if if_c ();
  clk_division_if if_d ();

  clk_division #(.DIV_RATIO(1000)) u_a (.clk(clk), .rst_n(rst_a), .div_if(if_a));
  clk_division #(.DIV_RATIO(5))    u_b (.clk(clk), .rst_n(rst_b), .div_if(if_b));
  clk_division #(.DIV_RATIO(2))    u_c (.clk(clk), .rst_n(rst_c), .div_if(if_c));
  clk_division #(.DIV_RATIO(10))   u_d (.clk(clk), .rst_n(rst_d), .div_if(if_d));

  assign co_s = {if_d.clk_out, if_c.clk_out, if_b.clk_out, if_a.clk_out};
`ifdef DIVISION_TICK_EN
  assign tk_s = {if_d.tick, if_c.tick, if_b.tick, if_a.tick};
`else
  assign tk_s = 4'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int id, input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q[id].push_back(e);
  endtask

  task automatic push_rise(input int id, input int c);
    push(id, K_RISE, c);
`ifdef DIVISION_TICK_EN
    push(id, K_TICK, c);
`endif
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_ev(input int id, input int kind);
    ev_t e;
    n_tests++;
    if (exp_q[id].size() == 0) begin
      n_fail++;
      $display("FAIL dut%0d unexpected event: got kind %0d at cycle %0d expected none",
               id, kind, cyc);
    end else begin
      e = exp_q[id].pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL dut%0d event: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                 id, kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (co_s[i] !== prev_co[i]) begin
        check_ev(i, co_s[i] ? K_RISE : K_FALL);
        prev_co[i] = co_s[i];
      end
      if (tk_s[i] === 1'b1) check_ev(i, K_TICK);
    end
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    if_a.en = 1'b1; if_b.en = 1'b1; if_c.en = 1'b1; if_d.en = 1'b1;
    #3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset clk_out dut%0d", i), co_s[i], 1'b0);
      chk($sformatf("reset tick dut%0d", i), tk_s[i], 1'b0);
    end

    fork
      // Ratio 1000: steady state, mid-period reset, restart.
      begin
        int b;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        b = cyc;
        for (int k = 0; k < 4; k++) begin
          push_rise(0, b + 500 + 1000 * k);
          if (k < 3) push(0, K_FALL, b + 1000 + 1000 * k);
        end
        repeat (3700) @(negedge clk);
        #2 rst_a = 1'b0;
        push(0, K_FALL, cyc + 1);
        #1;
        chk("async clear clk_out", if_a.clk_out, 1'b0);
        chk("async clear tick", tk_s[0], 1'b0);
        repeat (4) @(negedge clk);
        rst_a = 1'b1;
        b = cyc;
        push_rise(0, b + 500);
        repeat (520) @(negedge clk);
        if_a.en = 1'b0;
      end
      // Ratio 5: low 3, high 2.
      begin
        int b;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        b = cyc;
        for (int k = 0; k < 5; k++) begin
          push_rise(1, b + 3 + 5 * k);
          push(1, K_FALL, b + 5 + 5 * k);
        end
        repeat (26) @(negedge clk);
        if_b.en = 1'b0;
      end
      // Ratio 2: clk/2.
      begin
        int b;
        repeat (3) @(negedge clk);
        rst_c = 1'b1;
        b = cyc;
        for (int k = 0; k < 5; k++) begin
          push_rise(2, b + 1 + 2 * k);
          push(2, K_FALL, b + 2 + 2 * k);
        end
        repeat (10) @(negedge clk);
        if_c.en = 1'b0;
      end
      // Ratio 10: freeze for 7 cycles at phase 3.
      begin
        int b;
        repeat (3) @(negedge clk);
        rst_d = 1'b1;
        b = cyc;
        push_rise(3, b + 12);
        push(3, K_FALL, b + 17);
        push_rise(3, b + 22);
        push(3, K_FALL, b + 27);
        repeat (3) @(negedge clk);
        if_d.en = 1'b0;
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          chk($sformatf("frozen clk_out %0d", i), if_d.clk_out, 1'b0);
          chk($sformatf("frozen tick %0d", i), tk_s[3], 1'b0);
        end
        if_d.en = 1'b1;
        repeat (18) @(negedge clk);
        if_d.en = 1'b0;
      end
    join

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (exp_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL dut%0d missing events: got %0d pending expected 0",
                 i, exp_q[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
